instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/lc3b_types.sv | 16 +
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word and the fetch-stage state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  function automatic lc3b_word pc_inc(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// LC-3b instruction fetch stage: one outstanding memory read, a one-entry
// instruction holding register, and redirect handling that never drops a read in flight.
module instr_fetch
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     mem_resp,
  input  lc3b_word mem_rdata,
  output logic     mem_read,
  output lc3b_word mem_address,
  input  logic     load_ifid,
  output lc3b_word instr,
  output lc3b_word pc_out,
  output logic     instr_valid,
  input  logic     redirect,
  input  lc3b_word redirect_pc
);

  fetch_state_t state_q, state_d;
  lc3b_word     pc_q, pc_d;
  lc3b_word     pending_pc_q, pending_pc_d;
  lc3b_word     instr_q, instr_d;
  lc3b_word     pc_out_q, pc_out_d;
  logic         instr_valid_q, instr_valid_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    unique case (state_q)
      FETCH: begin
        if (mem_resp && redirect) begin
          pc_d = redirect_pc;
        end else if (mem_resp) begin
          instr_d       = mem_rdata;
          pc_out_d      = pc_inc(pc_q);
          instr_valid_d = 1'b1;
          pc_d          = pc_inc(pc_q);
          state_d       = HOLD;
        end else if (redirect) begin
          // Read is still in flight; wait for it to drain before retargeting.
          pending_pc_d = redirect_pc;
          state_d      = FLUSH;
        end
      end
      HOLD: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          state_d       = FETCH;
        end else if (load_ifid) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      FLUSH: begin
        if (redirect) pending_pc_d = redirect_pc;
        if (mem_resp) begin
          pc_d    = redirect ? redirect_pc : pending_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pending_pc_q  <= '0;
      instr_q       <= '0;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // FLUSH keeps requesting the same address so the outstanding read completes.
  assign mem_read    = (state_q != HOLD);
  assign mem_address = pc_q;
  assign instr       = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, normal fetch/hold, redirects, PC wrap, async reset.
module tb_instr_fetch;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset;
  logic     mem_resp;
  lc3b_word mem_rdata;
  logic     mem_read;
  lc3b_word mem_address;
  logic     load_ifid;
  lc3b_word instr;
  lc3b_word pc_out;
  logic     instr_valid;
  logic     redirect;
  lc3b_word redirect_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_address(mem_address), .load_ifid(load_ifid),
    .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    mem_resp = 0; load_ifid = 0; redirect = 0;
  endtask

  initial begin
    reset = 1; mem_resp = 0; mem_rdata = 16'h0; load_ifid = 0;
    redirect = 0; redirect_pc = 16'h0;
    @(negedge clk);
    check("rst_valid", {15'h0, instr_valid}, 16'h0);
    check("rst_instr", instr, 16'h0);
    check("rst_pc_out", pc_out, 16'h0);
    check("rst_addr", mem_address, 16'h0000);
    step();
    reset = 0;

    // Normal fetch, response after 3 cycles
    for (int i = 0; i < 3; i++) begin
      check("wait_read", {15'h0, mem_read}, 16'h1);
      check("wait_addr", mem_address, 16'h0000);
      check("wait_valid", {15'h0, instr_valid}, 16'h0);
      step();
    end
    mem_resp = 1; mem_rdata = 16'h1241;
    step();
    idle(); mem_rdata = 16'hDEAD;
    check("f1_valid", {15'h0, instr_valid}, 16'h1);
    check("f1_instr", instr, 16'h1241);
    check("f1_pc_out", pc_out, 16'h0002);
    check("f1_read", {15'h0, mem_read}, 16'h0);
    load_ifid = 1;
    step();
    idle();
    check("f1_consumed", {15'h0, instr_valid}, 16'h0);
    check("f1_next_read", {15'h0, mem_read}, 16'h1);
    check("f1_next_addr", mem_address, 16'h0002);

    // Hold for 5 cycles with load_ifid low
    mem_resp = 1; mem_rdata = 16'hABCD;
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      check("hold_instr", instr, 16'hABCD);
      check("hold_pc_out", pc_out, 16'h0004);
      check("hold_read", {15'h0, mem_read}, 16'h0);
      check("hold_valid", {15'h0, instr_valid}, 16'h1);
      step();
    end
    load_ifid = 1;
    step();
    idle();
    check("hold_next_addr", mem_address, 16'h0004);

    // Redirect one cycle into FETCH, response two cycles later
    step();
    redirect = 1; redirect_pc = 16'h3000;
    step();
    idle();
    check("flush_read", {15'h0, mem_read}, 16'h1);
    check("flush_addr", mem_address, 16'h0004);
    check("flush_valid", {15'h0, instr_valid}, 16'h0);
    step();
    mem_resp = 1; mem_rdata = 16'hBAD0;
    step();
    idle();
    check("flush_drop_valid", {15'h0, instr_valid}, 16'h0);
    check("flush_new_addr", mem_address, 16'h3000);
    check("flush_new_read", {15'h0, mem_read}, 16'h1);

    // Redirect and load_ifid together in HOLD
    mem_resp = 1; mem_rdata = 16'h1111;
    step();
    idle();
    check("h2_instr", instr, 16'h1111);
    check("h2_pc_out", pc_out, 16'h3002);
    redirect = 1; redirect_pc = 16'h4000; load_ifid = 1;
    step();
    idle();
    check("hredir_valid", {15'h0, instr_valid}, 16'h0);
    check("hredir_addr", mem_address, 16'h4000);
    check("hredir_read", {15'h0, mem_read}, 16'h1);

    // Redirect coincident with mem_resp in FETCH, then PC wrap
    redirect = 1; redirect_pc = 16'hFFFE; mem_resp = 1; mem_rdata = 16'hBAD1;
    step();
    idle();
    check("fredir_valid", {15'h0, instr_valid}, 16'h0);
    check("fredir_addr", mem_address, 16'hFFFE);
    mem_resp = 1; mem_rdata = 16'h2222;
    step();
    idle();
    check("wrap_instr", instr, 16'h2222);
    check("wrap_pc_out", pc_out, 16'h0000);
    load_ifid = 1;
    step();
    idle();
    check("wrap_next_addr", mem_address, 16'h0000);

    // FLUSH: later redirect with mem_resp wins
    redirect = 1; redirect_pc = 16'h5000;
    step();
    idle();
    check("fl2_addr", mem_address, 16'h0000);
    redirect = 1; redirect_pc = 16'h0010; mem_resp = 1; mem_rdata = 16'hBAD2;
    step();
    idle();
    check("fl2_latest", mem_address, 16'h0010);
    check("fl2_valid", {15'h0, instr_valid}, 16'h0);

    // Asynchronous reset mid-FETCH at 0x0010
    check("pre_rst_instr", instr, 16'h2222);
    #2 reset = 1; mem_resp = 1; mem_rdata = 16'hBAD3;
    #1;
    check("arst_instr", instr, 16'h0);
    check("arst_pc_out", pc_out, 16'h0);
    check("arst_addr", mem_address, 16'h0000);
    step();
    idle();
    reset = 0;
    check("post_rst_read", {15'h0, mem_read}, 16'h1);
    check("post_rst_addr", mem_address, 16'h0000);
    check("post_rst_valid", {15'h0, instr_valid}, 16'h0);
    step();
    check("post_rst_hold_addr", mem_address, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
